riscv_multi_ctrl: RTL
=====================

// Module: riscv_multi_ctrl
// PURPOSE
// Multicycle RISC-V control FSM. It sits directly upstream of the multicycle datapath and drives every datapath
// control line (write enables, mux selects, ALU op, imm format) one state per cycle. Opcode and funct fields are
// taken from the datapath instruction register; the zero flag comes from the ALU. Supports lw, sw, R-type
// (add/sub/and/or), I-type ALU (addi/andi/ori), beq and jal.
// PARAMETERS
// none: encodings are fixed (alu_op_* from alu.vh, imm_src_* from riscv/datapath.vh, mux codes below)
// PORTS
// clk        in   1  system clock, all state changes on posedge
// rst        in   1  synchronous reset, ACTIVE-LOW (rst==0 resets on next posedge)
// op         in   7  instr[6:0] from IR
// funct3     in   3  instr[14:12]
// funct7b5   in   1  instr[30]
// zero       in   1  ALU zero flag (combinational, current cycle)
// pc_we      out  1  PC register write enable
// adr_src    out  1  memory address: 0=PC, 1=result
// ir_we      out  1  IR/old_pc latch enable
// mem_we     out  1  data memory write enable
// reg_we     out  1  register file write enable
// alu_src_a  out  2  00=PC, 01=old_pc, 10=rd1
// alu_src_b  out  2  00=rd2, 01=ext_imm, 10=const 4
// res_src    out  2  00=alu_out reg, 01=mem read data, 10=ALU result
// imm_src    out  2  imm_src_itype/stype/btype/jtype
// alu_ctrl   out  2  alu_op_add/sub/and/or
// state      out  4  current state (debug / bench visibility)
// BEHAVIOUR
// - States (encoding 0..10): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
// - Transitions: FETCH->DECODE. DECODE: lw/sw->MEMADR, R(0110011)->EXECR, I(0010011)->EXECI,
//   beq(1100011)->BEQ, jal(1101111)->JAL, any other op->FETCH (no write of any kind). MEMADR: lw->MEMREAD,
//   sw->MEMWRITE. MEMREAD->MEMWB. EXECR, EXECI, JAL->ALUWB. MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
// - Cycles per instr: beq 3, sw/R/I/jal 4, lw 5.
// - Per-state outputs (unlisted enables=0; unlisted selects don't-care, driven 0):
//   FETCH: adr_src=0, ir_we=1, a=PC, b=4, add, res=ALU result, pc_we=1.
//   DECODE: a=old_pc, b=imm, add, imm_src=btype (branch target into alu_out).
//   MEMADR: a=rd1, b=imm, add, imm_src=itype (lw) / stype (sw).
//   MEMREAD: res=alu_out, adr_src=1.   MEMWB: res=read data, reg_we=1.
//   MEMWRITE: res=alu_out, adr_src=1, mem_we=1.
//   EXECR: a=rd1, b=rd2, ALU op from funct.   EXECI: a=rd1, b=imm, itype, ALU op from funct3.
//   ALUWB: res=alu_out, reg_we=1.
//   BEQ: a=rd1, b=rd2, sub, res=alu_out, pc_we=zero.
//   JAL: a=old_pc, b=4, add, imm_src=jtype, res=alu_out, pc_we=1 (alu_out holds target from DECODE).
// - DECODE uses btype for all opcodes. In JAL, alu_out holds old_pc+B-imm instead of the jal target.
//   jal is therefore not architecturally correct until the DECODE imm_src tracks the opcode (required fix
//   before jal sign-off). The bench for jal checks rd only.
// - ALU decode: R: 000+funct7b5=1 sub, 000+funct7b5=0 add, 110 or, 111 and. I: 000 add (funct7b5 ignored),
//   110 or, 111 and. Other funct3: add, instruction still completes.
// - Output timing: all outputs are Moore on state, except pc_we in BEQ (zero) and alu_ctrl (funct).
// - Reset: while rst==0, pc_we, ir_we, mem_we and reg_we are forced 0 combinationally. state=FETCH after
//   the first posedge with rst==0. Reset mid-instruction abandons it with no partial write.
// - In the first cycle after rst rises, FETCH is active (ir_we=1, pc_we=1).
// TESTING
// - reset: rst=0 for 2 clks in state MEMWB -> state=0 (FETCH), reg_we=0 during reset. After release,
//   FETCH outputs ir_we=1, pc_we=1, alu_ctrl=add.
// - lw x6,-4(x9) (0xffc4a303): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. reg_we=1 only in cycle 5,
//   res_src=01. Integrated: x9=8, mem[1]=0xdeadc0de -> x6=0xdeadc0de, PC=4.
// - sw x6,8(x9) (0x0064a423): 4 cycles, mem_we=1 only in MEMWRITE with adr_src=1 and imm_src=stype.
//   Integrated: mem[4]=0xdeadc0de.
// - or x4,x5,x6 (0x0062e233): EXECR alu_ctrl=or, ALUWB reg_we=1. sub (0x40628233): alu_ctrl=sub.
//   addi with funct7b5=1: alu_ctrl=add.
// - beq x4,x4,-12 (0xfe420ae3) at PC 12: zero=1 in BEQ -> pc_we=1, PC=0 after 3 cycles.
//   Same instr with zero=0 -> pc_we=0, PC stays 16.
// - illegal op 0x0000007f: FETCH->DECODE->FETCH, no reg_we/mem_we. rst=0 asserted during MEMWRITE ->
//   mem_we=0 that cycle.

Source files
------------

// File: rtl/riscv_multi_ctrl.sv
// Purpose : multicycle RISC-V control FSM (lw, sw, add/sub/and/or, addi/andi/ori, beq, jal).
// Latency : one state per clock; beq 3, sw/R/I/jal 4, lw 5 cycles per instruction.
// Backpr. : none; the datapath follows every cycle. A low rst masks all write enables at once.
//
// Ports:
//   clk                   system clock, all state changes on posedge
//   rst                   synchronous reset, active low
//   op/funct3/funct7b5    instruction fields from the datapath IR
//   zero                  ALU zero flag, current cycle (only used in BEQ)
//   pc_we/ir_we/mem_we/reg_we   write enables (forced 0 while rst is low)
//   adr_src/alu_src_a/alu_src_b/res_src/imm_src/alu_ctrl   datapath selects
//   state                 current FSM state, for debug
module riscv_multi_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_we,
   output logic       adr_src,
   output logic       ir_we,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] res_src,
   output logic [1:0] imm_src,
   output logic [1:0] alu_ctrl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC  = 2'b00;
   localparam logic [1:0] SRCA_OLD = 2'b01;
   localparam logic [1:0] SRCA_RD1 = 2'b10;
   localparam logic [1:0] SRCB_RD2 = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_4   = 2'b10;
   localparam logic [1:0] RES_OUT  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_ALU  = 2'b10;

   state_t state_q, state_d;

   // raw enables before the reset mask
   logic pc_we_s, ir_we_s, mem_we_s, reg_we_s;

   // funct decode; sub only exists for R-type (I-type bit 30 is immediate data)
   function automatic logic [1:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                             input logic is_r);
      logic [1:0] r;
      r = ALU_ADD;
      case (f3)
         3'b000:  r = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b110:  r = ALU_OR;
         3'b111:  r = ALU_AND;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;  // unsupported opcode: drop it, no writes
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we_s   = 1'b0;
      ir_we_s   = 1'b0;
      mem_we_s  = 1'b0;
      reg_we_s  = 1'b0;
      adr_src   = 1'b0;
      alu_src_a = SRCA_PC;
      alu_src_b = SRCB_RD2;
      res_src   = RES_OUT;
      imm_src   = IMM_I;
      alu_ctrl  = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_we_s   = 1'b1;
            pc_we_s   = 1'b1;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_4;
            res_src   = RES_ALU;
         end
         S_DECODE: begin
            // branch target precomputed into alu_out regardless of opcode
            alu_src_a = SRCA_OLD;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            res_src  = RES_MEM;
            reg_we_s = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src  = 1'b1;
            mem_we_s = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            alu_ctrl  = alu_decode(funct3, funct7b5, 1'b1);
         end
         S_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = alu_decode(funct3, funct7b5, 1'b0);
         end
         S_ALUWB: begin
            reg_we_s = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            alu_ctrl  = ALU_SUB;
            pc_we_s   = zero;
         end
         S_JAL: begin
            // link value old_pc+4 goes to alu_out; PC loads the target held in alu_out
            alu_src_a = SRCA_OLD;
            alu_src_b = SRCB_4;
            imm_src   = IMM_J;
            pc_we_s   = 1'b1;
         end
         default: ;
      endcase
   end

   // mask enables combinationally so a reset mid-instruction never writes
   assign pc_we  = pc_we_s  & rst;
   assign ir_we  = ir_we_s  & rst;
   assign mem_we = mem_we_s & rst;
   assign reg_we = reg_we_s & rst;
   assign state  = state_q;

endmodule
